// File: rtl/hamming_decode_scheduler.sv
// hamming_decode_scheduler
// Round-robin arbiter that time-shares one external combinational Hamming(71,64)
// decoder between NUM_REQ requesters. One transaction is in flight at a time:
// IDLE (grant) -> ISSUE (decoder settles) -> CAPTURE (latch result) -> HOLD
// (wait for downstream). Also keeps a saturating count of results that had a
// non-zero syndrome.
module hamming_decode_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*71-1:0]  req_data,
   output logic                   dec_enable,
   output logic [70:0]            dec_data_in,
   input  logic [63:0]            dec_decoded_out,
   input  logic [6:0]             dec_syndrome,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [63:0]            out_data,
   output logic [ID_W-1:0]        out_id,
   output logic                   out_err,
   output logic [6:0]             out_syndrome,
   input  logic                   err_clear,
   output logic [CNT_W-1:0]       err_count
);

   localparam int unsigned CW_W   = 71;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned SYN_W  = 7;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                dec_enable_q, dec_enable_d;
   logic [CW_W-1:0]     dec_data_in_q, dec_data_in_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [ID_W-1:0]     out_id_q, out_id_d;
   logic                out_err_q, out_err_d;
   logic [SYN_W-1:0]    out_syndrome_q, out_syndrome_d;
   logic [CNT_W-1:0]    err_count_q, err_count_d;

   logic [CW_W-1:0]     req_cw [NUM_REQ];
   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W-1:0]     scan_idx;

   // Split the flat request bus into one codeword per requester.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_cw[i] = req_data[CW_W*i +: CW_W];
      end
   end

   // Round-robin search starting at rr_ptr; first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Accept is offered only in IDLE, and only to the granted requester.
   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Next-state and next-output computation for the transaction sequencer.
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      id_d           = id_q;
      dec_enable_d   = dec_enable_q;
      dec_data_in_d  = dec_data_in_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_id_d       = out_id_q;
      out_err_d      = out_err_q;
      out_syndrome_d = out_syndrome_q;

      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               dec_data_in_d = req_cw[grant_idx];
               dec_enable_d  = 1'b1;
               id_d          = grant_idx;
               rr_ptr_d      = ID_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            out_data_d     = dec_decoded_out;
            out_syndrome_d = dec_syndrome;
            out_err_d      = |dec_syndrome;
            out_id_d       = id_q;
            out_valid_d    = 1'b1;
            dec_enable_d   = 1'b0;
            state_d        = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Saturating error counter; a clear wins over a same-edge increment.
   always_comb begin
      err_count_d = err_count_q;
      if (err_clear) begin
         err_count_d = '0;
      end else if (state_q == CAPTURE && (|dec_syndrome) && err_count_q != '1) begin
         err_count_d = err_count_q + CNT_W'(1);
      end
   end

   // State and registered outputs; reset drops any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         id_q           <= '0;
         dec_enable_q   <= 1'b0;
         dec_data_in_q  <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_id_q       <= '0;
         out_err_q      <= 1'b0;
         out_syndrome_q <= '0;
         err_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         id_q           <= id_d;
         dec_enable_q   <= dec_enable_d;
         dec_data_in_q  <= dec_data_in_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_id_q       <= out_id_d;
         out_err_q      <= out_err_d;
         out_syndrome_q <= out_syndrome_d;
         err_count_q    <= err_count_d;
      end
   end

   assign dec_enable   = dec_enable_q;
   assign dec_data_in  = dec_data_in_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_id       = out_id_q;
   assign out_err      = out_err_q;
   assign out_syndrome = out_syndrome_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_hamming_decode_scheduler.sv
// Testbench for hamming_decode_scheduler: a behavioural Hamming(71,64) decoder
// (codeword bit i = position i+1, parity at powers of two) is attached to two
// instances, one with a 2-bit error counter for the saturation corner.
module tb_hamming_decode_scheduler;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [283:0]  req_data;
   logic          out_ready;
   logic          err_clear;

   logic [3:0]    req_ready;
   logic          dec_enable;
   logic [70:0]   dec_data_in;
   logic [63:0]   dec_decoded_out;
   logic [6:0]    dec_syndrome;
   logic          out_valid;
   logic [63:0]   out_data;
   logic [1:0]    out_id;
   logic          out_err;
   logic [6:0]    out_syndrome;
   logic [15:0]   err_count;

   logic [3:0]    req_ready_s;
   logic          dec_enable_s;
   logic [70:0]   dec_data_in_s;
   logic [63:0]   dec_decoded_out_s;
   logic [6:0]    dec_syndrome_s;
   logic          out_valid_s;
   logic [63:0]   out_data_s;
   logic [1:0]    out_id_s;
   logic          out_err_s;
   logic [6:0]    out_syndrome_s;
   logic [1:0]    err_count_s;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hamming_decode_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .dec_enable(dec_enable), .dec_data_in(dec_data_in),
      .dec_decoded_out(dec_decoded_out), .dec_syndrome(dec_syndrome),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .out_err(out_err), .out_syndrome(out_syndrome),
      .err_clear(err_clear), .err_count(err_count)
   );

   hamming_decode_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_data(req_data), .dec_enable(dec_enable_s), .dec_data_in(dec_data_in_s),
      .dec_decoded_out(dec_decoded_out_s), .dec_syndrome(dec_syndrome_s),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_id(out_id_s), .out_err(out_err_s), .out_syndrome(out_syndrome_s),
      .err_clear(err_clear), .err_count(err_count_s)
   );

   // Behavioural decoder: returns {syndrome, corrected data}.
   function automatic logic [70:0] ham_dec(input logic [70:0] cw);
      logic [6:0]  s;
      logic [70:0] c;
      logic [63:0] d;
      int          j;
      s = '0;
      for (int p = 1; p <= 71; p++) if (cw[p-1]) s = s ^ 7'(p);
      c = cw;
      if (s != 7'd0 && int'(s) <= 71) c[int'(s)-1] = ~c[int'(s)-1];
      d = '0;
      j = 0;
      for (int p = 1; p <= 71; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = c[p-1];
            j++;
         end
      end
      return {s, d};
   endfunction

   assign {dec_syndrome, dec_decoded_out}     = ham_dec(dec_data_in);
   assign {dec_syndrome_s, dec_decoded_out_s} = ham_dec(dec_data_in_s);

   function automatic logic [283:0] pack4(input logic [70:0] c0, input logic [70:0] c1,
                                          input logic [70:0] c2, input logic [70:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      req_valid = '0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // One full transaction with out_ready=1, checking every cycle of the sequence.
   task automatic do_txn(input logic [3:0] v, input logic [283:0] d, input logic [1:0] eid,
                         input logic [63:0] edata, input logic [6:0] esyn, input logic eerr,
                         input logic clr);
      logic [3:0] onehot;
      onehot    = 4'b0001 << eid;
      req_valid = v;
      req_data  = d;
      out_ready = 1'b1;
      err_clear = 1'b0;
      #1;
      chk("req_ready grant", 71'(req_ready), 71'(onehot));
      tick();
      req_data = ~d;
      chk("dec_enable issue", 71'(dec_enable), 71'(1));
      chk("dec_data_in", dec_data_in, d[71*int'(eid) +: 71]);
      chk("out_valid issue", 71'(out_valid), 71'(0));
      chk("req_ready busy", 71'(req_ready), 71'(0));
      tick();
      if (clr) err_clear = 1'b1;
      chk("out_valid capture", 71'(out_valid), 71'(0));
      chk("dec_enable capture", 71'(dec_enable), 71'(1));
      tick();
      err_clear = 1'b0;
      chk("out_valid hold", 71'(out_valid), 71'(1));
      chk("out_id", 71'(out_id), 71'(eid));
      chk("out_data", 71'(out_data), 71'(edata));
      chk("out_syndrome", 71'(out_syndrome), 71'(esyn));
      chk("out_err", 71'(out_err), 71'(eerr));
      chk("dec_enable hold", 71'(dec_enable), 71'(0));
      tick();
      chk("out_valid idle", 71'(out_valid), 71'(0));
      req_valid = '0;
      req_data  = '0;
   endtask

   typedef struct {
      logic [3:0]   valid;
      logic [283:0] data;
      logic [1:0]   id;
      logic [63:0]  dout;
      logic [6:0]   syn;
      logic         err;
      logic [15:0]  cnt;
   } vec_t;

   localparam logic [70:0] CW_A   = 71'h7;   // data 1, clean
   localparam logic [70:0] CW_B   = 71'h19;  // data 2, clean
   localparam logic [70:0] CW_C   = 71'h4B;  // data 8, clean
   localparam logic [70:0] CW_E3  = 71'h3;   // CW_A with position 3 flipped
   localparam logic [70:0] CW_E5  = 71'h10;  // zero word with position 5 flipped
   localparam logic [70:0] CW_TOP = {1'b1, 6'd0, 1'b1, 59'd0, 4'hB}; // data bit 63 only

   vec_t vecs [8];

   initial begin
      logic [283:0] dd;
      rst = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      tick();
      tick();
      chk("rst out_valid", 71'(out_valid), 71'(0));
      chk("rst dec_enable", 71'(dec_enable), 71'(0));
      chk("rst dec_data_in", dec_data_in, 71'(0));
      chk("rst out_data", 71'(out_data), 71'(0));
      chk("rst out_id", 71'(out_id), 71'(0));
      chk("rst out_err", 71'(out_err), 71'(0));
      chk("rst out_syndrome", 71'(out_syndrome), 71'(0));
      chk("rst err_count", 71'(err_count), 71'(0));
      chk("rst req_ready", 71'(req_ready), 71'(0));
      rst = 1'b0;

      // Table: rr pointer and error count carry from one row to the next.
      dd = pack4(CW_A, CW_TOP, CW_C, CW_E3);
      vecs[0] = '{4'b0001, pack4(71'h0, 71'h0, 71'h0, 71'h0), 2'd0, 64'h0, 7'd0, 1'b0, 16'd0};
      vecs[1] = '{4'b0100, pack4(71'h0, 71'h0, CW_E5, 71'h0), 2'd2, 64'h0, 7'd5, 1'b1, 16'd1};
      vecs[2] = '{4'b1111, dd, 2'd3, 64'h1, 7'd3, 1'b1, 16'd2};
      vecs[3] = '{4'b1111, dd, 2'd0, 64'h1, 7'd0, 1'b0, 16'd2};
      vecs[4] = '{4'b1111, dd, 2'd1, 64'h8000_0000_0000_0000, 7'd0, 1'b0, 16'd2};
      vecs[5] = '{4'b1111, dd, 2'd2, 64'h8, 7'd0, 1'b0, 16'd2};
      vecs[6] = '{4'b0011, dd, 2'd0, 64'h1, 7'd0, 1'b0, 16'd2};
      vecs[7] = '{4'b1001, pack4(CW_A, 71'h0, 71'h0, CW_B), 2'd3, 64'h2, 7'd0, 1'b0, 16'd2};
      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i].valid, vecs[i].data, vecs[i].id, vecs[i].dout, vecs[i].syn,
                vecs[i].err, 1'b0);
         chk($sformatf("tbl%0d err_count", i), 71'(err_count), 71'(vecs[i].cnt));
      end

      // Round-robin from reset: all requesting, then alternate requesters.
      pulse_reset();
      for (int i = 0; i < 5; i++) do_txn(4'b1111, '0, 2'(i % 4), 64'h0, 7'd0, 1'b0, 1'b0);
      pulse_reset();
      do_txn(4'b1010, '0, 2'd1, 64'h0, 7'd0, 1'b0, 1'b0);
      do_txn(4'b1010, '0, 2'd3, 64'h0, 7'd0, 1'b0, 1'b0);
      do_txn(4'b1010, '0, 2'd1, 64'h0, 7'd0, 1'b0, 1'b0);

      // Downstream stall in HOLD with other requesters waiting.
      pulse_reset();
      req_valid = 4'b0001;
      req_data  = pack4(CW_E3, 71'h0, 71'h0, 71'h0);
      out_ready = 1'b0;
      tick();
      req_valid = 4'b1111;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("stall out_valid", 71'(out_valid), 71'(1));
         chk("stall out_data", 71'(out_data), 71'(1));
         chk("stall out_id", 71'(out_id), 71'(0));
         chk("stall out_err", 71'(out_err), 71'(1));
         chk("stall out_syndrome", 71'(out_syndrome), 71'(3));
         chk("stall req_ready", 71'(req_ready), 71'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("post-stall out_valid", 71'(out_valid), 71'(0));
      chk("post-stall req_ready", 71'(req_ready), 71'(4'b0010));
      chk("post-stall err_count", 71'(err_count), 71'(1));
      req_valid = '0;

      // Error-count saturation on the 2-bit instance, then clear on a CAPTURE edge.
      pulse_reset();
      for (int k = 0; k < 6; k++) begin
         do_txn(4'b0001, pack4(CW_E5, 71'h0, 71'h0, 71'h0), 2'd0, 64'h0, 7'd5, 1'b1, 1'b0);
         chk("sat err_count_s", 71'(err_count_s), 71'((k + 1 > 3) ? 3 : k + 1));
         chk("sat err_count", 71'(err_count), 71'(k + 1));
      end
      do_txn(4'b0001, pack4(CW_E5, 71'h0, 71'h0, 71'h0), 2'd0, 64'h0, 7'd5, 1'b1, 1'b1);
      chk("clr-on-capture err_count", 71'(err_count), 71'(0));
      chk("clr-on-capture err_count_s", 71'(err_count_s), 71'(0));
      do_txn(4'b0001, pack4(CW_E5, 71'h0, 71'h0, 71'h0), 2'd0, 64'h0, 7'd5, 1'b1, 1'b0);
      chk("recount err_count_s", 71'(err_count_s), 71'(1));
      do_txn(4'b0001, pack4(CW_A, 71'h0, 71'h0, 71'h0), 2'd0, 64'h1, 7'd0, 1'b0, 1'b0);
      chk("clean err_count_s", 71'(err_count_s), 71'(1));
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("idle clear err_count", 71'(err_count), 71'(0));

      // Reset while in ISSUE drops the transaction and resets the rr pointer.
      pulse_reset();
      do_txn(4'b0001, '0, 2'd0, 64'h0, 7'd0, 1'b0, 1'b0);
      req_valid = 4'b1111;
      req_data  = dd;
      tick();
      chk("pre-rst dec_enable", 71'(dec_enable), 71'(1));
      req_valid = '0;
      rst = 1'b1;
      #2;
      chk("issue-rst dec_enable", 71'(dec_enable), 71'(0));
      chk("issue-rst dec_data_in", dec_data_in, 71'(0));
      chk("issue-rst out_valid", 71'(out_valid), 71'(0));
      rst = 1'b0;
      do_txn(4'b1111, dd, 2'd0, 64'h1, 7'd0, 1'b0, 1'b0);

      // Reset while in HOLD clears every result output and the counter.
      req_valid = 4'b0100;
      req_data  = pack4(71'h0, 71'h0, CW_E3, 71'h0);
      out_ready = 1'b0;
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("pre-rst out_valid", 71'(out_valid), 71'(1));
      chk("pre-rst out_id", 71'(out_id), 71'(2));
      chk("pre-rst err_count", 71'(err_count), 71'(1));
      rst = 1'b1;
      #2;
      chk("hold-rst out_valid", 71'(out_valid), 71'(0));
      chk("hold-rst out_data", 71'(out_data), 71'(0));
      chk("hold-rst out_id", 71'(out_id), 71'(0));
      chk("hold-rst out_err", 71'(out_err), 71'(0));
      chk("hold-rst out_syndrome", 71'(out_syndrome), 71'(0));
      chk("hold-rst err_count", 71'(err_count), 71'(0));
      chk("hold-rst dec_enable", 71'(dec_enable), 71'(0));
      rst = 1'b0;
      do_txn(4'b1111, dd, 2'd0, 64'h1, 7'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
